// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the registered stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_RR   = 1'b1
  } mode_e;

  // Select width for n channels; never narrower than one bit.
  function automatic int unsigned calc_selw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A load wins over a same-cycle drain; a drain leaves the data in place.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1-to-NCH valid/ready demultiplexer, addressed or round-robin routing.
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = calc_selw(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic                 sel_err,
  output logic [SELW-1:0]      rr_ptr
);

  localparam logic [SELW:0]   NchExt  = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LastPtr = SELW'(NCH - 1);

  mode_e           mode_sel;
  logic [SELW-1:0] tgt;
  logic            tgt_ok;
  logic            accept;
  logic [NCH-1:0]  load;
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
  logic            sel_err_q, sel_err_d;

  assign mode_sel = mode_e'(mode);

  // Target select and acceptance; an out-of-range target is always ready so it gets dropped.
  always_comb begin
    tgt      = (mode_sel == MODE_RR) ? rr_ptr_q : in_sel;
    tgt_ok   = ({1'b0, tgt} < NchExt);
    in_ready = 1'b1;
    for (int k = 0; k < int'(NCH); k++) begin
      if (tgt == SELW'(k)) in_ready = ~out_valid[k] | out_ready[k];
    end
    accept = in_valid & in_ready;
    load   = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      load[k] = accept & (tgt == SELW'(k));
    end
  end

  // Pointer wraps at NCH-1 so non-power-of-two channel counts never reach a dead slot.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && (mode_sel == MODE_RR)) begin
      rr_ptr_d = (rr_ptr_q == LastPtr) ? '0 : rr_ptr_q + SELW'(1);
    end
    sel_err_d = accept & ~tgt_ok;
  end

  // Pointer and error-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      sel_err_q <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign rr_ptr  = rr_ptr_q;
  assign sel_err = sel_err_q;

  for (genvar k = 0; k < int'(NCH); k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk_i  (clk),
      .rst_i  (rst),
      .load_i (load[k]),
      .data_i (in_data),
      .ready_i(out_ready[k]),
      .valid_o(out_valid[k]),
      .data_o (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule
